// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: ROM address/data, redirect request and the
// valid/ready instruction stream towards decode.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [31:0]           out_pc;

    // The fetch unit itself: drives the ROM address and the decode stream.
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    // The surroundings: ROM, branch resolution and decode.
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and
// buffers one instruction (with its PC) towards decode. Handles redirects,
// back-pressure, end-of-program (all-zero word) and misaligned targets.
module instr_fetch_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [31:0]           pc;
    logic [31:0]           pc_next;
    logic [31:0]           pc_plus_4;

    logic                  buf_valid;
    logic                  buf_valid_next;
    logic [DATA_WIDTH-1:0] buf_instr;
    logic [DATA_WIDTH-1:0] buf_instr_next;
    logic [31:0]           buf_pc;
    logic [31:0]           buf_pc_next;

    logic                  load_ok;
    logic                  redirect_misaligned;
    logic                  end_of_program;
    logic                  unused_pc_bits;

    // Only the word-address bits reach the ROM; the upper bits alias and the
    // two low bits are zero by construction (misaligned targets never load).
    assign bus.imem_addr = pc[ADDR_WIDTH+1:2];
    assign unused_pc_bits = ^pc;

    assign pc_plus_4           = pc + 32'd4;
    assign load_ok             = !buf_valid || bus.out_ready;
    assign redirect_misaligned = bus.redirect_pc[1:0] != 2'b00;
    assign end_of_program      = bus.imem_data == '0;

    assign bus.out_valid = buf_valid;
    assign bus.out_instr = buf_instr;
    assign bus.out_pc    = buf_pc;

    assign halted = state == ST_HALT;
    assign fault  = state == ST_FAULT;

    // Register update; reset empties the buffer and restarts fetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            buf_valid <= buf_valid_next;
            buf_instr <= buf_instr_next;
            buf_pc    <= buf_pc_next;
        end
    end

    // Next-state, PC and buffer decisions in priority order: misaligned
    // redirect, aligned redirect (flushes the buffer), end of program, capture.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        buf_valid_next = buf_valid;
        buf_instr_next = buf_instr;
        buf_pc_next    = buf_pc;

        case (state)
            ST_FETCH: begin
                if (bus.redirect_valid && redirect_misaligned) begin
                    buf_valid_next = 1'b0;
                    state_next     = ST_FAULT;
                end else if (bus.redirect_valid) begin
                    pc_next        = bus.redirect_pc;
                    buf_valid_next = 1'b0;
                end else if (load_ok && end_of_program) begin
                    buf_valid_next = 1'b0;
                    state_next     = ST_HALT;
                end else if (load_ok) begin
                    buf_instr_next = bus.imem_data;
                    buf_pc_next    = pc;
                    buf_valid_next = 1'b1;
                    pc_next        = pc_plus_4;
                end
            end

            ST_HALT: begin
                buf_valid_next = 1'b0;
                if (bus.redirect_valid && redirect_misaligned) begin
                    state_next = ST_FAULT;
                end else if (bus.redirect_valid) begin
                    pc_next    = bus.redirect_pc;
                    state_next = ST_FETCH;
                end
            end

            ST_FAULT: begin
                buf_valid_next = 1'b0;
            end

            default: begin
                buf_valid_next = 1'b0;
                state_next     = ST_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a small combinational ROM.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;
    logic halted;
    logic fault;

    int checks;
    int errors;

    logic [31:0] rom [0:255];
    logic [31:0] prog [0:7];

    instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_if ();

    instr_fetch_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .halted(halted),
        .fault (fault)
    );

    assign bus_if.imem_data = rom[bus_if.imem_addr];

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.out_ready      = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        tick();
        tick();
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", bus_if.out_instr); end
        checks++; if (bus_if.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", bus_if.out_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (bus_if.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", bus_if.imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, bus_if.out_valid); end
            checks++; if (bus_if.out_pc !== 32'(i * 4)) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, bus_if.out_pc, 32'(i * 4)); end
            checks++; if (bus_if.out_instr !== prog[i]) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, bus_if.out_instr, prog[i]); end
        end
        tick();
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL end_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL end_halted: got %b expected 1", halted); end
        checks++; if (bus_if.imem_addr !== 8'h08) begin errors++; $display("[TB] FAIL end_addr: got %h expected 08", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00b60a63) begin errors++; $display("[TB] FAIL halt_instr_hold: got %h expected 00b60a63", bus_if.out_instr); end
        checks++; if (bus_if.imem_addr !== 8'h08) begin errors++; $display("[TB] FAIL halt_addr_hold: got %h expected 08", bus_if.imem_addr); end
    endtask

    task automatic test_back_pressure();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus_if.out_instr !== 32'h00052503) begin errors++; $display("[TB] FAIL bp_first: got %h expected 00052503", bus_if.out_instr); end
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, bus_if.out_valid); end
            checks++; if (bus_if.out_instr !== 32'h00052503) begin errors++; $display("[TB] FAIL bp_instr[%0d]: got %h expected 00052503", i, bus_if.out_instr); end
            checks++; if (bus_if.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_pc[%0d]: got %h expected 0", i, bus_if.out_pc); end
        end
        bus_if.out_ready = 1'b1;
        tick();
        checks++; if (bus_if.out_instr !== 32'h0085a583) begin errors++; $display("[TB] FAIL bp_release_instr: got %h expected 0085a583", bus_if.out_instr); end
        checks++; if (bus_if.out_pc !== 32'h04) begin errors++; $display("[TB] FAIL bp_release_pc: got %h expected 04", bus_if.out_pc); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00a58633) begin errors++; $display("[TB] FAIL bp_next_instr: got %h expected 00a58633", bus_if.out_instr); end
        checks++; if (bus_if.out_pc !== 32'h08) begin errors++; $display("[TB] FAIL bp_next_pc: got %h expected 08", bus_if.out_pc); end
    endtask

    task automatic test_redirect();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h30;
        tick();
        bus_if.redirect_valid = 1'b0;
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.imem_addr !== 8'h0C) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 0c", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00c6f6b3 || bus_if.out_pc !== 32'h30 || bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_beat0: got %h@%h v=%b expected 00c6f6b3@30 v=1", bus_if.out_instr, bus_if.out_pc, bus_if.out_valid); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00c6e733 || bus_if.out_pc !== 32'h34) begin errors++; $display("[TB] FAIL redir_beat1: got %h@%h expected 00c6e733@34", bus_if.out_instr, bus_if.out_pc); end
        tick();
        checks++; if (halted !== 1'b1 || bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_halt: got halted=%b valid=%b expected 1/0", halted, bus_if.out_valid); end
        checks++; if (bus_if.imem_addr !== 8'h0E) begin errors++; $display("[TB] FAIL redir_halt_addr: got %h expected 0e", bus_if.imem_addr); end
    endtask

    task automatic test_halt_redirect();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h10;
        tick();
        bus_if.redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_exit: got %b expected 0", halted); end
        checks++; if (bus_if.imem_addr !== 8'h04) begin errors++; $display("[TB] FAIL halt_exit_addr: got %h expected 04", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h02b60063 || bus_if.out_pc !== 32'h10 || bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_exit_beat: got %h@%h v=%b expected 02b60063@10 v=1", bus_if.out_instr, bus_if.out_pc, bus_if.out_valid); end
    endtask

    task automatic test_fault();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h06;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_set: got %b expected 1", fault); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.imem_addr !== 8'h05) begin errors++; $display("[TB] FAIL fault_pc_hold: got %h expected 05", bus_if.imem_addr); end
        bus_if.redirect_pc = 32'h20;
        tick();
        bus_if.redirect_valid = 1'b0;
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b expected 1", fault); end
        checks++; if (bus_if.imem_addr !== 8'h05) begin errors++; $display("[TB] FAIL fault_redir_ignored: got %h expected 05", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_idle: got valid=%b fault=%b expected 0/1", bus_if.out_valid, fault); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_clear: got %b expected 0", fault); end
        checks++; if (bus_if.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL fault_reset_addr: got %h expected 00", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00052503 || bus_if.out_pc !== 32'h0 || bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fault_restart: got %h@%h v=%b expected 00052503@0 v=1", bus_if.out_instr, bus_if.out_pc, bus_if.out_valid); end
    endtask

    task automatic test_reset_midstream();
        bus_if.out_ready = 1'b0;
        tick();
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_hold_valid: got %b expected 1", bus_if.out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.out_instr !== 32'h0) begin errors++; $display("[TB] FAIL mid_instr: got %h expected 0", bus_if.out_instr); end
        checks++; if (bus_if.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL mid_pc: got %h expected 0", bus_if.out_pc); end
        checks++; if (bus_if.imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL mid_addr: got %h expected 00", bus_if.imem_addr); end
    endtask

    task automatic test_alias();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h434;
        tick();
        bus_if.redirect_valid = 1'b0;
        checks++; if (bus_if.imem_addr !== 8'h0D) begin errors++; $display("[TB] FAIL alias_addr: got %h expected 0d", bus_if.imem_addr); end
        tick();
        checks++; if (bus_if.out_instr !== 32'h00c6e733 || bus_if.out_pc !== 32'h434) begin errors++; $display("[TB] FAIL alias_beat: got %h@%h expected 00c6e733@434", bus_if.out_instr, bus_if.out_pc); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL alias_halt: got %b expected 1", halted); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        prog[0] = 32'h00052503; prog[1] = 32'h0085a583;
        prog[2] = 32'h00a58633; prog[3] = 32'h00c2a423;
        prog[4] = 32'h02b60063; prog[5] = 32'h40b606b3;
        prog[6] = 32'h40d60633; prog[7] = 32'h00b60a63;
        for (int i = 0; i < 8; i++) rom[i] = prog[i];
        rom[8'h0C] = 32'h00c6f6b3;
        rom[8'h0D] = 32'h00c6e733;

        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_halt_redirect();
        test_fault();
        test_reset_midstream();
        test_alias();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the text-memory ROM and downstream of the branch/jump resolution logic.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Registers the returned instruction together with its PC into a one-entry output buffer, using a valid/ready handshake towards decode.
- Handles redirects (branch/jump), back-pressure, end-of-program detection (all-zero word) and misaligned-target faults.

Parameters:
- DATA_WIDTH, 32, instruction word width; must match the ROM data width.
- ADDR_WIDTH, 8, ROM word-address width; ROM holds 2**ADDR_WIDTH words.
- RESET_PC, 32'h00000000, byte address loaded into the PC on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  word address to the ROM = pc[ADDR_WIDTH+1:2]; purely combinational from pc.
- imem_data  input  DATA_WIDTH  instruction word returned combinationally by the ROM for imem_addr.
- redirect_valid  input  1  one-cycle request to load a new PC.
- redirect_pc  input  32  byte-address redirect target.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the buffered instruction this cycle when out_valid=1.
- out_instr  output  DATA_WIDTH  buffered instruction.
- out_pc  output  32  byte PC of out_instr.
- halted  output  1  high while in HALT state.
- fault  output  1  high while in FAULT state.

Behaviour:
- Reset (rst=1 at a clock edge), which overrides everything:
  - pc=RESET_PC, state=FETCH.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0.
  - Reset applied mid-operation discards any buffered instruction.
- Address mapping:
  - imem_addr = pc[ADDR_WIDTH+1:2]; pc[1:0] is always 0.
  - Upper pc bits are ignored, so addresses alias modulo 4*2**ADDR_WIDTH.
  - pc increments modulo 2**32.
- States: FETCH, HALT, FAULT. halted = (state==HALT); fault = (state==FAULT).
- Buffer capacity: load_ok = !out_valid || out_ready. The buffer is one deep, and a new word is captured in the same cycle the old one is consumed, so the throughput is 1 instr/cycle.
- FETCH, priority order per cycle:
  1. redirect_valid=1 with redirect_pc[1:0]!=0: out_valid<=0, pc unchanged, state<=FAULT.
  2. redirect_valid=1 and aligned: pc<=redirect_pc, out_valid<=0. This flushes the buffer, even if out_ready=1 in the same cycle; the flushed instruction counts as consumed/dropped. No capture this cycle.
  3. load_ok and imem_data==0: end of program. No capture, pc unchanged, out_valid<=0, state<=HALT.
  4. load_ok and imem_data!=0: out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
  5. Otherwise (out_valid=1, out_ready=0): hold all outputs and pc stable.
- Latency: the instruction at pc appears on out_instr one cycle after the cycle in which it is addressed and load_ok=1. The first instruction after reset release is valid on the 1st edge after rst deasserts.
- HALT:
  - Buffer already empty; out_valid stays 0 and pc holds.
  - Aligned redirect: pc<=redirect_pc, state<=FETCH.
  - Misaligned redirect: state<=FAULT.
- FAULT:
  - Sticky; out_valid=0, pc holds.
  - Left only via rst; redirects are ignored.
- out_ready with out_valid=0 has no effect. out_instr/out_pc keep their last value when out_valid=0.

Test Plan:
- ROM loaded with words 0..7 = 00052503, 0085a583, 00a58633, 00c2a423, 02b60063, 40b606b3, 40d60633, 00b60a63; words 8..11 = 0; word 0x0C = 00c6f6b3; word 0x0D = 00c6e733.
- Reset, out_ready=1 -> 8 consecutive valid beats: out_pc 0x00..0x1C with the words above, one per cycle. Then out_valid=0 and halted=1 with pc=0x20.
- Back-pressure: out_ready=0 for 3 cycles after the first beat -> out_instr=00052503/out_pc=0 held stable. Release -> 0085a583 @0x04 on the next cycle, with no beat lost or duplicated.
- Redirect while buffer holds 0x08 and out_ready=1: redirect_pc=0x30 -> buffer flushed (out_valid=0 that cycle). Next beats: 00c6f6b3 @0x30, 00c6e733 @0x34, then HALT at pc=0x38.
- From HALT, redirect_pc=0x10 -> state FETCH, halted=0. Next beat: 02b60063 @0x10.
- Misaligned redirect_pc=0x06 -> out_valid=0 and fault=1 from the next cycle. A later aligned redirect is ignored. rst -> fault=0 and fetch restarts at 0x00.
- rst asserted while out_valid=1 and out_ready=0 -> on the next cycle out_valid=0, out_instr=0, out_pc=0, pc=0.
